// File: rtl/bisection_search.sv
// Closed-loop bisection controller: searches the reference-current code i_ref
// until the plant's measured_q lands within TOL of desired_q.
module bisection_search #(
    parameter int WIDTH  = 10,
    parameter int TOL    = 1,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [WIDTH-1:0] desired_q,
    input  logic [WIDTH-1:0] measured_q,
    input  logic [WIDTH-1:0] i_ref_setup,
    output logic [WIDTH-1:0] i_ref
);

    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] TOL_C    = WIDTH'(TOL);
    localparam logic [WIDTH-1:0] MAX_CODE = '1;
    localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);

    typedef enum logic [2:0] {IDLE, SET, WAIT, CMP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] error;
    logic             converged;
    logic             exhausted;
    logic [CNT_W-1:0] settle_cnt;

    // Unsigned distance without wrap: subtract the smaller from the larger.
    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [WIDTH:0]   span_sum;
    logic [WIDTH-1:0] mid;
    logic [WIDTH-1:0] q_err;
    logic             q_below;
    logic             within_tol;
    logic [WIDTH-1:0] low_next;
    logic [WIDTH-1:0] high_next;

    always_comb begin
        span_sum   = {1'b0, low} + {1'b0, high};
        mid        = span_sum[WIDTH:1];
        q_err      = abs_diff(desired_q, measured_q);
        q_below    = measured_q < desired_q;
        within_tol = q_err <= TOL_C;
        low_next   = i_ref + ONE_C;
        high_next  = i_ref - ONE_C;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            i_ref      <= '0;
            low        <= '0;
            high       <= '0;
            error      <= '1;
            converged  <= 1'b0;
            exhausted  <= 1'b0;
            settle_cnt <= '0;
        end else if (ready) begin
            case (state)
                IDLE: begin
                    low   <= '0;
                    high  <= i_ref_setup;
                    state <= SET;
                end
                SET: begin
                    i_ref      <= mid;
                    settle_cnt <= SETTLE_C;
                    state      <= WAIT;
                end
                WAIT: begin
                    settle_cnt <= settle_cnt - CNT_ONE;
                    if (settle_cnt <= CNT_ONE)
                        state <= CMP;
                end
                CMP: begin
                    error <= q_err;
                    if (within_tol) begin
                        converged <= 1'b1;
                        state     <= DONE;
                    end else if (q_below) begin
                        // Raising low past the top code or past high means no code left.
                        if (i_ref == MAX_CODE || low_next > high) begin
                            exhausted <= 1'b1;
                            state     <= DONE;
                        end else begin
                            low   <= low_next;
                            state <= SET;
                        end
                    end else begin
                        if (i_ref == '0 || low > high_next) begin
                            exhausted <= 1'b1;
                            state     <= DONE;
                        end else begin
                            high  <= high_next;
                            state <= SET;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bisection_search.sv
// Scoreboard bench for bisection_search: directed searches against identity,
// table and flat plants; a monitor pops expected results on each completion.
module tb_bisection_search;

    localparam int WIDTH  = 10;
    localparam int TOL    = 1;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic [WIDTH-1:0] desired_q;
    logic [WIDTH-1:0] measured_q;
    logic [WIDTH-1:0] i_ref_setup;
    logic [WIDTH-1:0] i_ref;

    bisection_search #(.WIDTH(WIDTH), .TOL(TOL), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .desired_q  (desired_q),
        .measured_q (measured_q),
        .i_ref_setup(i_ref_setup),
        .i_ref      (i_ref)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             conv;
        logic             exh;
        logic [WIDTH-1:0] iref;
        logic [WIDTH-1:0] err;
        int               cycles;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] seq_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int done_cnt  = 0;
    int plant_mode = 0;

    logic [WIDTH-1:0] q_table [1024];

    // Plant: 0 = identity, 1 = table q = min(2*i, 1023), 2 = flat q = 500
    always @(posedge clk) begin
        case (plant_mode)
            0:       measured_q <= i_ref;
            1:       measured_q <= q_table[i_ref];
            default: measured_q <= 10'd500;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic c, input logic x, input int ir,
                                input int er, input int cy);
        exp_t e;
        e.conv   = c;
        e.exh    = x;
        e.iref   = WIDTH'(ir);
        e.err    = WIDTH'(er);
        e.cycles = cy;
        return e;
    endfunction

    // Monitor: i_ref trajectory and completion events, decoupled from stimulus
    logic             done_now;
    logic             done_prev = 1'b0;
    logic [WIDTH-1:0] prev_iref = '0;
    logic [WIDTH-1:0] seq_exp;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (i_ref !== prev_iref) begin
            if (seq_q.size() > 0) begin
                seq_exp = seq_q.pop_front();
                check("iref_seq", int'(i_ref), int'(seq_exp));
            end
            prev_iref = i_ref;
        end
        done_now = dut.converged | dut.exhausted;
        if (done_now && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("converged", int'(dut.converged), int'(mon_e.conv));
                check("exhausted", int'(dut.exhausted), int'(mon_e.exh));
                check("final_iref", int'(i_ref), int'(mon_e.iref));
                check("final_error", int'(dut.error), int'(mon_e.err));
                check("cycles_to_done", cyc - start_cyc, mon_e.cycles);
            end
            done_cnt++;
        end
        done_prev = done_now;
    end

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_iref", int'(i_ref), 0);
        check("rst_error", int'(dut.error), 1023);
        check("rst_conv", int'(dut.converged), 0);
        check("rst_exh", int'(dut.exhausted), 0);
        check("rst_low_high", int'(dut.low) + int'(dut.high), 0);
        rst = 1'b0;
    endtask

    task automatic start_search(input int setup, input int desired, input int mode,
                                input exp_t e);
        i_ref_setup = WIDTH'(setup);
        desired_q   = WIDTH'(desired);
        plant_mode  = mode;
        exp_q.push_back(e);
        ready     = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) check("timeout_done", done_cnt, target);
    endtask

    task automatic hold_check(input int exp_iref, input int c, input int x);
        desired_q = ~desired_q;
        repeat (8) @(negedge clk);
        check("hold_iref", int'(i_ref), exp_iref);
        check("hold_conv", int'(dut.converged), c);
        check("hold_exh", int'(dut.exhausted), x);
    endtask

    task automatic push_seq_290();
        seq_q.push_back(10'd511); seq_q.push_back(10'd255);
        seq_q.push_back(10'd383); seq_q.push_back(10'd319);
        seq_q.push_back(10'd287); seq_q.push_back(10'd303);
        seq_q.push_back(10'd295); seq_q.push_back(10'd291);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            q_table[i] = (i * 2 > 1023) ? 10'd1023 : WIDTH'(i * 2);
        rst         = 1'b1;
        ready       = 1'b0;
        desired_q   = '0;
        i_ref_setup = '0;

        // Identity plant, target 290: 8 iterations
        do_reset();
        push_seq_290();
        start_search(1023, 290, 0, mk(1, 0, 291, 1, 33));
        wait_done(1);
        hold_check(291, 1, 0);

        // Table plant q=2i: converges at 145 after 9 iterations
        do_reset();
        start_search(1023, 290, 1, mk(1, 0, 145, 0, 37));
        wait_done(2);
        check("table_measured_q", int'(measured_q), 290);
        hold_check(145, 1, 0);

        // Target above reachable range: exhausted at 511
        do_reset();
        start_search(511, 1023, 0, mk(0, 1, 511, 512, 41));
        wait_done(3);
        hold_check(511, 0, 1);

        // Target 0: converges at code 1 without underflow
        do_reset();
        start_search(1023, 0, 0, mk(1, 0, 1, 1, 37));
        wait_done(4);

        // ready dropped for 5 cycles during the first WAIT
        do_reset();
        push_seq_290();
        start_search(1023, 290, 0, mk(1, 0, 291, 1, 38));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        check("frozen_iref", int'(i_ref), 511);
        check("frozen_low", int'(dut.low), 0);
        check("frozen_high", int'(dut.high), 1023);
        check("frozen_cnt", int'(dut.settle_cnt), 2);
        ready = 1'b1;
        wait_done(5);

        // rst pulsed while in CMP, then a fresh search
        do_reset();
        i_ref_setup = 10'd1023;
        desired_q   = 10'd290;
        plant_mode  = 0;
        ready       = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_iref", int'(i_ref), 511);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_iref", int'(i_ref), 0);
        check("midrst_error", int'(dut.error), 1023);
        check("midrst_conv", int'(dut.converged), 0);
        rst       = 1'b0;
        start_cyc = cyc;
        exp_q.push_back(mk(1, 0, 291, 1, 33));
        @(posedge clk);
        push_seq_290();
        wait_done(6);

        // Zero span: only code 0 is tested
        do_reset();
        start_search(0, 0, 0, mk(1, 0, 0, 0, 5));
        wait_done(7);

        // Flat plant above target: walks down to 0 and exhausts
        do_reset();
        start_search(1023, 100, 2, mk(0, 1, 0, 400, 41));
        wait_done(8);
        hold_check(0, 0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        check("sequence_empty", seq_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
